// File: rtl/iris_spike_classifier_if.sv
// Handshake bundle between the SNN timing controller / result consumer and
// the spike classifier output stage.
interface iris_spike_classifier_if #(
    parameter int NUM_CLASSES = 3,
    parameter int CNT_W       = 7,
    parameter int IDX_W       = 2
);
    logic                   sample_reset;
    logic                   count_enable;
    logic                   result_valid;
    logic [NUM_CLASSES-1:0] spike_in;
    logic                   class_ready;
    logic                   class_valid;
    logic [IDX_W-1:0]       class_out;
    logic                   class_tie;
    logic [CNT_W-1:0]       max_count;
    logic                   overrun;

    // Controller / consumer side
    modport master (
        output sample_reset, count_enable, result_valid, spike_in, class_ready,
        input  class_valid, class_out, class_tie, max_count, overrun
    );

    // Classifier side
    modport slave (
        input  sample_reset, count_enable, result_valid, spike_in, class_ready,
        output class_valid, class_out, class_tie, max_count, overrun
    );
endinterface

// File: rtl/iris_spike_classifier.sv
// Iris spike classifier: per-class saturating spike counters, snapshot on
// result_valid, sequential argmax (one class per cycle, lowest index wins a
// tie) and a registered valid/ready result port with a sticky overrun flag.
module iris_spike_classifier #(
    parameter int NUM_CLASSES = 3,
    parameter int CNT_W       = 7,
    parameter int IDX_W       = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    iris_spike_classifier_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_VALID} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt      [NUM_CLASSES];
    logic [CNT_W-1:0] r_snap     [NUM_CLASSES];
    logic [CNT_W-1:0] w_cnt_nxt  [NUM_CLASSES];
    logic [CNT_W-1:0] w_snap_nxt [NUM_CLASSES];
    logic [CNT_W-1:0] r_best;
    logic [IDX_W-1:0] r_best_idx;
    logic [IDX_W-1:0] r_idx;
    logic             r_tie;
    logic [CNT_W-1:0] w_cur;
    logic [CNT_W-1:0] w_cmp_best;
    logic [IDX_W-1:0] w_cmp_idx;
    logic             w_cmp_tie;

    logic             r_class_valid;
    logic [IDX_W-1:0] r_class_out;
    logic             r_class_tie;
    logic [CNT_W-1:0] r_max_count;
    logic             r_overrun;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Next counter values; the snapshot sees the same-cycle spike, or the
    // pre-clear value when sample_reset wipes the counters this cycle.
    always_comb begin
        for (int i = 0; i < NUM_CLASSES; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (bus.sample_reset)
                w_cnt_nxt[i] = '0;
            else if (bus.count_enable && bus.spike_in[i])
                w_cnt_nxt[i] = sat_inc(r_cnt[i]);
            w_snap_nxt[i] = bus.sample_reset ? r_cnt[i] : w_cnt_nxt[i];
        end
    end

    // One argmax step: compare the current snapshot entry against the best.
    always_comb begin
        w_cur      = r_snap[r_idx];
        w_cmp_best = r_best;
        w_cmp_idx  = r_best_idx;
        w_cmp_tie  = r_tie;
        if (w_cur > r_best) begin
            w_cmp_best = w_cur;
            w_cmp_idx  = r_idx;
            w_cmp_tie  = 1'b0;
        end else if (w_cur == r_best) begin
            w_cmp_tie  = 1'b1;
        end
    end

    // Spike counters run regardless of the FSM state.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (reset) r_cnt[i] <= '0;
            else       r_cnt[i] <= w_cnt_nxt[i];
        end
    end

    // Snapshot, sequential argmax and result handshake.
    // Class 0 is taken as the initial best on the snapshot edge so that the
    // remaining classes finish in time for class_valid NUM_CLASSES cycles on.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            for (int i = 0; i < NUM_CLASSES; i++) r_snap[i] <= '0;
            r_best        <= '0;
            r_best_idx    <= '0;
            r_idx         <= '0;
            r_tie         <= 1'b0;
            r_class_valid <= 1'b0;
            r_class_out   <= '0;
            r_class_tie   <= 1'b0;
            r_max_count   <= '0;
            r_overrun     <= 1'b0;
        end else begin
            if (bus.result_valid && (r_state != S_IDLE))
                r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (bus.result_valid) begin
                        for (int i = 0; i < NUM_CLASSES; i++) r_snap[i] <= w_snap_nxt[i];
                        r_best     <= w_snap_nxt[0];
                        r_best_idx <= '0;
                        r_tie      <= 1'b0;
                        r_idx      <= IDX_W'(1);
                        r_state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_best     <= w_cmp_best;
                    r_best_idx <= w_cmp_idx;
                    r_tie      <= w_cmp_tie;
                    r_idx      <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_state       <= S_VALID;
                        r_class_valid <= 1'b1;
                        r_class_out   <= w_cmp_idx;
                        r_class_tie   <= w_cmp_tie;
                        r_max_count   <= w_cmp_best;
                    end
                end
                S_VALID: begin
                    if (bus.class_ready) begin
                        r_class_valid <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.class_valid = r_class_valid;
    assign bus.class_out   = r_class_out;
    assign bus.class_tie   = r_class_tie;
    assign bus.max_count   = r_max_count;
    assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_iris_spike_classifier.sv
// Directed bench for iris_spike_classifier: counting, argmax, ties,
// saturation, snapshot corner cases, handshake hold, overrun and reset abort.
module tb_iris_spike_classifier;

    localparam int NUM_CLASSES = 3;
    localparam int CNT_W       = 7;
    localparam int IDX_W       = 2;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    iris_spike_classifier_if #(
        .NUM_CLASSES(NUM_CLASSES), .CNT_W(CNT_W), .IDX_W(IDX_W)
    ) bus ();

    iris_spike_classifier #(
        .NUM_CLASSES(NUM_CLASSES), .CNT_W(CNT_W), .IDX_W(IDX_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_sr();
        bus.sample_reset = 1'b1;
        tick();
        bus.sample_reset = 1'b0;
    endtask

    // len enabled cycles; class i spikes in the first n_i of them.
    task automatic run_counts(input int n0, input int n1, input int n2, input int len);
        for (int k = 0; k < len; k++) begin
            bus.count_enable = 1'b1;
            bus.spike_in     = {(k < n2), (k < n1), (k < n0)};
            tick();
        end
        bus.count_enable = 1'b0;
        bus.spike_in     = '0;
    endtask

    // Pulse result_valid (with whatever other inputs are set) and check
    // class_valid rises exactly NUM_CLASSES cycles after that cycle.
    task automatic start(input string tag);
        bus.result_valid = 1'b1;
        tick();
        bus.result_valid = 1'b0;
        bus.sample_reset = 1'b0;
        bus.count_enable = 1'b0;
        bus.spike_in     = '0;
        chk({tag, "_vld_c1"}, 32'(bus.class_valid), 0);
        tick();
        chk({tag, "_vld_c2"}, 32'(bus.class_valid), 0);
        tick();
        chk({tag, "_vld_c3"}, 32'(bus.class_valid), 1);
    endtask

    task automatic chk_result(input string tag, input int cls, input int tie, input int mx);
        chk({tag, "_class"}, 32'(bus.class_out), 32'(cls));
        chk({tag, "_tie"},   32'(bus.class_tie), 32'(tie));
        chk({tag, "_max"},   32'(bus.max_count), 32'(mx));
    endtask

    task automatic ack(input string tag);
        bus.class_ready = 1'b1;
        tick();
        bus.class_ready = 1'b0;
        chk({tag, "_ack_vld"}, 32'(bus.class_valid), 0);
    endtask

    initial begin
        n_assert         = 0;
        n_fail           = 0;
        reset            = 1'b1;
        bus.sample_reset = 1'b0;
        bus.count_enable = 1'b0;
        bus.result_valid = 1'b0;
        bus.spike_in     = '0;
        bus.class_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_vld", 32'(bus.class_valid), 0);
        chk_result("rst", 0, 0, 0);
        chk("rst_ovr", 32'(bus.overrun), 0);

        // T1: 10/40/5 over 64 enabled cycles -> class 1, max 40
        pulse_sr();
        run_counts(10, 40, 5, 64);
        start("t1");
        chk_result("t1", 1, 0, 40);
        ack("t1");
        chk("t1_hold_class", 32'(bus.class_out), 1);

        // T2: 20/20/7 -> tie, lowest index wins
        pulse_sr();
        run_counts(20, 20, 7, 20);
        start("t2");
        chk_result("t2", 0, 1, 20);

        // T3: ready low for 10 cycles, result holds
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t3_vld", 32'(bus.class_valid), 1);
            chk_result("t3", 0, 1, 20);
        end
        ack("t3");

        // T4: all classes spike 200 cycles -> saturate at 127
        pulse_sr();
        run_counts(200, 200, 200, 200);
        start("t4");
        chk_result("t4", 0, 1, 127);
        ack("t4");

        // sample_reset with result_valid -> snapshot holds pre-clear counts
        pulse_sr();
        run_counts(0, 0, 3, 3);
        bus.sample_reset = 1'b1;
        start("preclr");
        chk_result("preclr", 2, 0, 3);
        ack("preclr");

        // spike in the result_valid cycle is part of the snapshot
        bus.count_enable = 1'b1;
        bus.spike_in     = 3'b010;
        start("samecyc");
        chk_result("samecyc", 1, 0, 1);
        ack("samecyc");

        // T5: sample_reset beats a simultaneous spike; overrun in VALID
        pulse_sr();
        run_counts(5, 5, 5, 5);
        bus.sample_reset = 1'b1;
        bus.count_enable = 1'b1;
        bus.spike_in     = 3'b111;
        tick();
        bus.sample_reset = 1'b0;
        bus.count_enable = 1'b0;
        bus.spike_in     = '0;
        chk("t5_ovr0", 32'(bus.overrun), 0);
        start("t5");
        chk_result("t5", 0, 1, 0);
        bus.result_valid = 1'b1;
        tick();
        bus.result_valid = 1'b0;
        chk("t5_ovr1", 32'(bus.overrun), 1);
        chk("t5_vld_kept", 32'(bus.class_valid), 1);
        chk_result("t5_kept", 0, 1, 0);
        ack("t5");
        chk("t5_ovr_sticky", 32'(bus.overrun), 1);

        // T6: reset during SCAN aborts; no class_valid afterwards
        pulse_sr();
        run_counts(1, 2, 3, 5);
        bus.result_valid = 1'b1;
        tick();
        bus.result_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_vld", 32'(bus.class_valid), 0);
        chk_result("t6", 0, 0, 0);
        chk("t6_ovr", 32'(bus.overrun), 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t6_no_vld", 32'(bus.class_valid), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
